// File: rtl/rtype_pkg.sv
// rtl/rtype_pkg.sv - shared widths, op_en bit indices and op-select enum for rtype_exec
package rtype_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = 5;
    localparam int NOPS   = 10;

    // Bit positions inside op_en
    localparam int OP_ADD_BIT  = 0;
    localparam int OP_SUB_BIT  = 1;
    localparam int OP_AND_BIT  = 2;
    localparam int OP_OR_BIT   = 3;
    localparam int OP_SLL_BIT  = 4;
    localparam int OP_SLT_BIT  = 5;
    localparam int OP_SLTU_BIT = 6;
    localparam int OP_XOR_BIT  = 7;
    localparam int OP_SRL_BIT  = 8;
    localparam int OP_SRA_BIT  = 9;

    // Encoded op select; each value equals its op_en bit index
    typedef enum logic [3:0] {
        OP_ADD  = 4'(OP_ADD_BIT),
        OP_SUB  = 4'(OP_SUB_BIT),
        OP_AND  = 4'(OP_AND_BIT),
        OP_OR   = 4'(OP_OR_BIT),
        OP_SLL  = 4'(OP_SLL_BIT),
        OP_SLT  = 4'(OP_SLT_BIT),
        OP_SLTU = 4'(OP_SLTU_BIT),
        OP_XOR  = 4'(OP_XOR_BIT),
        OP_SRL  = 4'(OP_SRL_BIT),
        OP_SRA  = 4'(OP_SRA_BIT)
    } op_sel_e;

    // Encode a one-hot op_en; the result is only meaningful when exactly one bit is set
    function automatic op_sel_e op_from_en(input logic [NOPS-1:0] en);
        op_sel_e sel;
        sel = OP_ADD;
        for (int i = 0; i < NOPS; i++) begin
            if (en[i]) begin
                sel = op_sel_e'(4'(i));
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rtype_alu.sv
// rtl/rtype_alu.sv - combinational R-type ALU (operands and op select to 32-bit result)
module rtype_alu
    import rtype_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  op_sel_e         op,
    output logic [XLEN-1:0] y
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    // Select the result for the decoded operation
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SRA:  y = $signed(a) >>> shamt;
            OP_SLT:  y = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: y = {{(XLEN-1){1'b0}}, lt_u};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rtype_exec.sv
// rtl/rtype_exec.sv - two-stage R-type issue/execute unit with register file; RTYPE_EXEC_FWD_EN enables hazard forwarding
module rtype_exec
    import rtype_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NOPS-1:0]   op_en,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              wr_en,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_illegal,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    input  logic              dbg_wr_en,
    input  logic [XLEN-1:0]   dbg_wr_data
);

    logic [XLEN-1:0]   rf_q [NREGS];
    logic [XLEN-1:0]   rf_d [NREGS];

    logic              ex_valid_q, ex_valid_d;
    op_sel_e           ex_op_q, ex_op_d;
    logic [XLEN-1:0]   ex_a_q, ex_a_d;
    logic [XLEN-1:0]   ex_b_q, ex_b_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_wr_q, ex_wr_d;
    logic              ex_illegal_q, ex_illegal_d;

    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              wb_illegal_q, wb_illegal_d;

    logic [XLEN-1:0]   rd1_val, rd2_val;
    logic [XLEN-1:0]   op_a, op_b;
    logic [XLEN-1:0]   alu_y, ex_result;
    logic              ex_writes;
    logic              haz_rs1, haz_rs2;
    logic              stall;
    logic              accept;
    logic              legal;

    rtype_alu u_alu (
        .a  (ex_a_q),
        .b  (ex_b_q),
        .op (ex_op_q),
        .y  (alu_y)
    );

    // Illegal instructions report zero data and never write
    assign ex_result = ex_illegal_q ? '0 : alu_y;
    assign ex_writes = ex_valid_q && ex_wr_q && (ex_rd_q != '0);
    assign haz_rs1   = ex_writes && (ex_rd_q == rs1);
    assign haz_rs2   = ex_writes && (ex_rd_q == rs2);

    assign rd1_val   = (rs1 == '0) ? '0 : rf_q[rs1];
    assign rd2_val   = (rs2 == '0) ? '0 : rf_q[rs2];
    assign dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

`ifdef RTYPE_EXEC_FWD_EN
    // Bypass the in-flight result into the issuing operands
    assign stall = 1'b0;
    assign op_a  = haz_rs1 ? ex_result : rd1_val;
    assign op_b  = haz_rs2 ? ex_result : rd2_val;
`else
    // Hold issue for the one cycle it takes the EXEC write to land in the file
    assign stall = in_valid && (haz_rs1 || haz_rs2);
    assign op_a  = rd1_val;
    assign op_b  = rd2_val;
`endif

    assign in_ready = !reset && !stall;
    assign accept   = in_valid && in_ready;
    assign legal    = $onehot(op_en);

    // Next-state for the EXEC stage, the write-back report and the register file
    always_comb begin
        ex_valid_d   = accept;
        ex_op_d      = ex_op_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_rd_d      = ex_rd_q;
        ex_wr_d      = ex_wr_q;
        ex_illegal_d = ex_illegal_q;
        if (accept) begin
            ex_op_d      = op_from_en(op_en);
            ex_a_d       = op_a;
            ex_b_d       = op_b;
            ex_rd_d      = rd;
            ex_wr_d      = wr_en && legal;
            ex_illegal_d = !legal;
        end

        wb_valid_d   = ex_valid_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        wb_illegal_d = wb_illegal_q;
        if (ex_valid_q) begin
            wb_rd_d      = ex_rd_q;
            wb_data_d    = ex_result;
            wb_illegal_d = ex_illegal_q;
        end

        rf_d = rf_q;
        if (dbg_wr_en && (dbg_addr != '0)) begin
            rf_d[dbg_addr] = dbg_wr_data;
        end
        if (ex_writes) begin
            rf_d[ex_rd_q] = ex_result;
        end
    end

    // State registers; reset drops any instruction in flight and clears the file
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_op_q      <= OP_ADD;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_rd_q      <= '0;
            ex_wr_q      <= 1'b0;
            ex_illegal_q <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_illegal_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op_q      <= ex_op_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_rd_q      <= ex_rd_d;
            ex_wr_q      <= ex_wr_d;
            ex_illegal_q <= ex_illegal_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            wb_illegal_q <= wb_illegal_d;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign wb_illegal = wb_illegal_q;

endmodule

// File: doc/rtype_exec.md
RTYPE_EXEC -- requirements
Module: rtype_exec

Interface
REQ-001 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port in_valid  input  1  decoded instruction present.
REQ-004 SHALL have port in_ready  output  1  instruction accepted this cycle when in_valid & in_ready.
REQ-005 SHALL have port op_en  input  10  enables {Rsra,Rsrl,Rxor,Rsltu,Rslt,Rsll,Ror,Rand,Rsub,Radd} (bit0 = Radd); one-hot expected.
REQ-006 SHALL have ports rs1, rs2, rd  input  5 each  source and destination register indices.
REQ-007 SHALL have port wr_en  input  1  write-back requested by decode.
REQ-008 SHALL have ports wb_valid (1), wb_rd (5), wb_data (32), wb_illegal (1)  output  registered write-back report.
REQ-009 SHALL have ports dbg_addr  input  5 and dbg_data  output  32  asynchronous register-file read; returns 0 for address 0.

Function
REQ-010 SHALL contain a 32x32 register file; x0 always reads 0, and writes to x0 are discarded.
REQ-011 SHALL be two-stage: ISSUE (cycle N: read rs1/rs2, latch operands, op, rd, wr_en) and EXEC (cycle N+1: compute, write register file at end of N+1).
REQ-012 SHALL present wb_valid=1 with wb_rd and wb_data in cycle N+2 for each accepted instruction; otherwise wb_valid=0.
REQ-013 SHALL compute ADD/SUB modulo 2^32; AND/OR/XOR bitwise; SLL/SRL/SRA shift by rs2 value bits [4:0], with SRA sign-filling; SLT signed and SLTU unsigned, both producing 0 or 1 zero-extended.
REQ-014 SHALL treat op_en with zero or more than one bit set as illegal: accepted, with no register write, wb_illegal=1, wb_data=0, and wb_valid=1.
REQ-015 SHALL write the register file only when wr_en=1, the op is legal, and rd!=0; wb_valid is still reported when wr_en=0.
REQ-016 SHALL define a hazard as: EXEC valid, writing, EXEC rd!=0, and (EXEC rd==rs1 or EXEC rd==rs2) for the ISSUE instruction.
REQ-017 SHALL hold in_ready=1 at all times except as stated in REQ-025; there is no downstream backpressure.
REQ-018 SHALL accept back-to-back instructions, one per cycle, when no stall is in effect.

Reset
REQ-019 SHALL, while reset=1, clear all register-file entries, EXEC valid, wb_valid, wb_rd, wb_data, and wb_illegal to 0.
REQ-020 SHALL hold in_ready=0 during reset.
REQ-021 SHALL discard an instruction in flight when reset asserts; it performs no write.
REQ-022 SHALL permit the first accept in the first cycle after reset deasserts.

Configuration
REQ-023 SHALL compile hazard forwarding in only when macro RTYPE_EXEC_FWD_EN is defined.
REQ-024 SHALL, with RTYPE_EXEC_FWD_EN defined, forward the EXEC result into the ISSUE operand on a hazard; in_ready stays 1.
REQ-025 SHALL, without RTYPE_EXEC_FWD_EN, drive in_ready=0 for exactly one cycle on a hazard, then read the updated register file.

Structure
REQ-026 SHALL place XLEN=32, NREGS=32, the op_en bit-index constants, and the op-select enum in package rtype_pkg.
REQ-027 SHALL implement the arithmetic in combinational sub-module rtype_alu (operands, op select -> 32-bit result).

Verification
REQ-028 SHALL cover: preload x1=5 and x2=3, ADD x3,x1,x2 -> wb_valid with wb_rd=3 and wb_data=8 two cycles after accept; dbg_addr=3 then reads 8.
REQ-029 SHALL cover: x1=0xFFFFFFF0 and x2=4; SRA -> 0xFFFFFFFF; SRL -> 0x0FFFFFFF; SLT x1,x2 -> 1; SLTU -> 0.
REQ-030 SHALL cover: ADD x3,x1,x2 followed by SUB x4,x3,x1 back-to-back -> x4=3, with zero stall under RTYPE_EXEC_FWD_EN and exactly one in_ready=0 cycle without it.
REQ-031 SHALL cover: ADD x0,x1,x2 -> wb_valid=1, and x0 still reads 0; op_en=10'b0000000011 -> wb_illegal=1 and no register changes.
REQ-032 SHALL cover: reset asserted in the cycle after an ADD to x5 is accepted -> x5 stays 0 and wb_valid stays 0.
